// File: rtl/dma_req_arbiter.sv
// Two-port DMA command arbiter: round-robin grant, one transaction
// outstanding, issue to write/read engines with ack timeout.
module dma_req_arbiter #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        i_sys_clk,
  input  logic        dma_rstn,
  input  logic [1:0]  i_cmd_valid,
  output logic [1:0]  o_cmd_ready,
  input  logic [1:0]  i_cmd_rw,
  input  logic [31:0] i_cmd_addr0,
  input  logic [31:0] i_cmd_addr1,
  input  logic [31:0] i_cmd_len0,
  input  logic [31:0] i_cmd_len1,
  output logic [1:0]  o_cmd_done,
  output logic        o_cmd_err,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_len,
  input  logic        wr_req_done,
  output logic        rd_req,
  input  logic        rd_ack,
  output logic [31:0] rd_addr,
  output logic [31:0] rd_len,
  input  logic        rd_req_done,
  output logic        o_busy,
  output logic        o_grant_id,
  output logic [15:0] o_xfer_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        rw_q;
  logic        last_q;
  logic        err_q;
  logic [31:0] len_q;
  logic [15:0] to_cnt;

  logic        pick;
  logic [31:0] sel_addr;
  logic [31:0] sel_len;
  logic [31:0] sel_wlen;
  logic        ack_m;
  logic        done_m;

  // Arbitration pick, selected command fields and matching handshakes
  always_comb begin
    pick     = (i_cmd_valid == 2'b11) ? ~last_q : i_cmd_valid[1];
    sel_addr = pick ? i_cmd_addr1 : i_cmd_addr0;
    sel_len  = pick ? i_cmd_len1 : i_cmd_len0;
    sel_wlen = (sel_len >> 2) + {31'b0, |sel_len[1:0]};
    ack_m    = rw_q ? rd_ack : wr_ack;
    done_m   = rw_q ? rd_req_done : wr_req_done;
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge i_sys_clk or negedge dma_rstn) begin
    if (!dma_rstn) begin
      state       <= IDLE;
      rw_q        <= 1'b0;
      last_q      <= 1'b1;
      err_q       <= 1'b0;
      len_q       <= '0;
      to_cnt      <= '0;
      o_cmd_ready <= '0;
      o_cmd_done  <= '0;
      o_cmd_err   <= 1'b0;
      wr_req      <= 1'b0;
      rd_req      <= 1'b0;
      wr_addr     <= '0;
      wr_len      <= '0;
      rd_addr     <= '0;
      rd_len      <= '0;
      o_busy      <= 1'b0;
      o_grant_id  <= 1'b0;
      o_xfer_cnt  <= '0;
    end else begin
      o_cmd_ready <= '0;
      o_cmd_done  <= '0;
      o_cmd_err   <= 1'b0;
      case (state)
        IDLE: begin
          // ready is shown while still idle so it never overlaps busy
          if (o_cmd_ready != 2'b00) begin
            state  <= ISSUE;
            o_busy <= 1'b1;
          end else if (|i_cmd_valid) begin
            o_cmd_ready <= pick ? 2'b10 : 2'b01;
            o_grant_id  <= pick;
            rw_q        <= i_cmd_rw[pick];
            len_q       <= sel_len;
            wr_addr     <= sel_addr;
            rd_addr     <= sel_addr;
            wr_len      <= sel_wlen;
            rd_len      <= sel_wlen;
          end
        end
        ISSUE: begin
          if (len_q == '0) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            err_q  <= 1'b0;
            wr_req <= ~rw_q;
            rd_req <= rw_q;
            to_cnt <= '0;
            state  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_m) begin
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            state  <= done_m ? RESP : WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            err_q  <= 1'b1;
            state  <= RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (done_m) state <= RESP;
        end
        RESP: begin
          o_cmd_done <= o_grant_id ? 2'b10 : 2'b01;
          o_cmd_err  <= err_q;
          last_q     <= o_grant_id;
          o_xfer_cnt <= o_xfer_cnt + 16'd1;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dma_req_arbiter.md
DMA_REQ_ARBITER -- requirements
Module: dma_req_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 4096, max cycles held in WAIT_ACK before abort.
REQ-002 The block SHALL have these ports, in this order:
- i_sys_clk  in  1  clock.
- dma_rstn  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  2  per-requester command valid; bit0 = port 0 (UART), bit1 = port 1 (ETH).
- o_cmd_ready  out  2  one-cycle accept pulse per port.
- i_cmd_rw  in  2  per port: 0 = write to memory, 1 = read.
- i_cmd_addr0 / i_cmd_addr1  in  32 each  byte address.
- i_cmd_len0 / i_cmd_len1  in  32 each  byte length.
- o_cmd_done  out  2  one-cycle completion pulse per port.
- o_cmd_err  out  1  valid with o_cmd_done; 1 = zero-length or timeout.
- wr_req  out  1;  wr_ack  in  1;  wr_addr  out  32;  wr_len  out  32 (words);  wr_req_done  in  1.
- rd_req  out  1;  rd_ack  in  1;  rd_addr  out  32;  rd_len  out  32 (words);  rd_req_done  in  1.
- o_busy  out  1  high when the FSM is not in IDLE.
- o_grant_id  out  1  port owning the current transaction.
- o_xfer_cnt  out  16  count of completed transactions.
REQ-003 The reset and clock SHALL be: reset dma_rstn, asynchronous, active-low; clock i_sys_clk.

Function
REQ-004 The block SHALL run a one-hot or encoded FSM with states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP; only one transaction SHALL be outstanding at a time.
REQ-005 In IDLE, if any i_cmd_valid bit is high, the block SHALL grant one port, pulse its o_cmd_ready for exactly that cycle, latch rw/addr/len/port, and go to ISSUE.
REQ-006 Arbitration SHALL be round-robin: with both ports valid, the port not granted last wins. After reset the last-grant pointer SHALL be 1, so port 0 wins the first tie.
REQ-007 Word length SHALL be ceil(len/4) = (len>>2) + (|len[1:0]). wr_addr/rd_addr SHALL equal the latched address unmodified. Both *_addr/*_len pairs SHALL carry the latched values.
REQ-008 A latched len of 0 SHALL skip ISSUE and go to RESP with err=1. No wr_req or rd_req SHALL be raised.
REQ-009 In ISSUE, the block SHALL register wr_req=1 (rw=0) or rd_req=1 (rw=1) and go to WAIT_ACK. req SHALL therefore be first visible 2 cycles after the o_cmd_ready pulse.
REQ-010 In WAIT_ACK, req SHALL stay high until the matching ack is sampled high. req SHALL then drop on the next edge and the FSM SHALL go to WAIT_DONE.
REQ-011 If the matching ack and matching done are sampled in the same cycle, the FSM SHALL go directly to RESP with err=0.
REQ-012 A 16-bit counter SHALL count cycles in WAIT_ACK. When it reaches TIMEOUT_CYC-1 without ack, the block SHALL drop req and go to RESP with err=1. The counter SHALL clear on entering WAIT_ACK.
REQ-013 In WAIT_DONE, the block SHALL wait indefinitely for the matching done (wr_req_done for write, rd_req_done for read), then go to RESP.
REQ-014 Non-matching ack/done inputs, or any ack/done seen outside WAIT_ACK/WAIT_DONE, SHALL be ignored.
REQ-015 In RESP, the block SHALL:
- pulse o_cmd_done[grant] for one cycle, with o_cmd_err valid in that same cycle;
- update the last-grant pointer;
- increment o_xfer_cnt (mod 2^16, also on error);
- return to IDLE.
A new grant SHALL NOT occur before the next cycle.
REQ-016 o_cmd_ready SHALL never be high while o_busy is high, and SHALL never have both bits set.
REQ-017 o_grant_id SHALL hold the latched port from acceptance until the block returns to IDLE.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 On dma_rstn low, all of the following SHALL clear immediately, including mid-transaction:
- FSM to IDLE;
- o_cmd_ready, o_cmd_done, o_cmd_err, wr_req, rd_req, o_busy, o_grant_id to 0;
- o_xfer_cnt and the timeout counter to 0;
- *_addr/*_len to 0;
- last-grant pointer to 1.
No done pulse SHALL be emitted for an aborted transaction.

Verification
REQ-020 Port0 write, addr=0x1000_0000, len=1024; ack 3 cycles after wr_req; wr_req_done 20 cycles later -> wr_len=256, wr_addr=0x1000_0000, o_cmd_done=2'b01, err=0, o_xfer_cnt=1.
REQ-021 Both ports valid in the same cycle after reset, both reads, len=6 -> port0 granted first with rd_len=2, then port1; a third tie goes to port0.
REQ-022 Port1 len=0 -> no req pulse; o_cmd_done=2'b10 with err=1 three cycles after acceptance.
REQ-023 TIMEOUT_CYC=16, ack never asserted -> wr_req drops after 16 cycles in WAIT_ACK; done with err=1; a later valid command is accepted normally.
REQ-024 The following SHALL be covered:
- wr_ack and wr_req_done in the same cycle -> RESP next, err=0.
- stray rd_req_done during a write -> ignored.
- dma_rstn asserted in WAIT_DONE -> all outputs 0, no o_cmd_done pulse.
